gelato_operand_collector: RTL
=============================

Name: gelato_operand_collector

Overview:
- Sits between the warp scheduler/issue stage and the execution units.
- Accepts issued `inst_t` instructions and allocates each one a `collector_entry_t`.
- Reads the source operands (rs1..rs3) from the banked warp register file, arbitrating per bank.
- Dispatches the instruction with its full warp-wide operand data once every operand is collected.

Parameters:
- NUM_COLLECTORS, 4, number of collector entries (`COLLECTOR_NUM`).
- NUM_BANKS, 4, number of register file banks (`BANK_NUM`), power of two.
- NUM_RS, 3, source operands per instruction (`RS_NUM`).
- WARP_REG_WIDTH, THREAD_NUM*DATA_WIDTH = 1024, width of one warp register (`warp_reg_t`).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  issue stage presents an instruction.
- inst_ready  out  1  a collector entry is free.
- inst  in  $bits(inst_t)  issued instruction.
- bank_req_valid  out  NUM_BANKS  per-bank read request.
- bank_req_warp  out  NUM_BANKS x $bits(warp_num_t)  warp of each request.
- bank_req_reg  out  NUM_BANKS x $bits(reg_num_t)  register of each request.
- bank_rsp_valid  in  NUM_BANKS  read data valid; exactly 1 cycle after the request.
- bank_rsp_data  in  NUM_BANKS x WARP_REG_WIDTH  read data.
- dispatch_valid  out  1  a fully collected instruction is offered.
- dispatch_ready  in  1  execution unit accepts.
- dispatch_inst  out  $bits(inst_t)  dispatched instruction.
- dispatch_rs_data  out  NUM_RS x WARP_REG_WIDTH  operand data, rs1 in slot 0.

Behaviour:
- Entry states: FREE -> COLLECT -> READY -> FREE.
- Reset (async, rst_n=0): all entries FREE, all `rs_valid`=0, in-flight tags cleared, round-robin pointers=0.
  - Outputs at reset: inst_ready=1, bank_req_valid=0, dispatch_valid=0, dispatch_inst=0, dispatch_rs_data=0.
  - Reset mid-operation drops every entry and in-flight read; late bank_rsp_valid after reset is ignored.
- Allocation:
  - inst_ready = OR of FREE flags, evaluated on registered state. An entry freed by dispatch this cycle is not reallocatable until the next cycle.
  - On inst_valid&&inst_ready, the lowest-index FREE entry captures inst and rs = {rs1, rs2, rs3}.
  - rs_valid[i] is set at capture if rs[i]==0; x0 operands read as all-zero data.
  - If all operands are valid at capture, the entry goes straight to READY; otherwise it goes to COLLECT.
- Bank mapping: bank = (rs + warp_num) mod NUM_BANKS, computed on the low bits.
- Request issue:
  - An operand is pending if it is not valid and not in flight.
  - Per bank, one request per cycle, granted round-robin across collectors.
  - Within a collector, the lowest rs index pending on that bank wins.
  - Grant registers the tag {collector, rs index} for that bank and marks the operand in flight.
  - The round-robin pointer advances to the granted collector + 1.
  - Entries captured in cycle C first request in C+1.
- Response:
  - bank_rsp_valid[b] writes rs_data and sets rs_valid for the tagged operand, then clears in-flight.
  - Responses on different banks in the same cycle are all accepted.
  - A response without a live tag is ignored.
  - An entry moves COLLECT -> READY on the edge where its last operand becomes valid.
- Dispatch:
  - Round-robin select among READY entries.
  - dispatch_valid/inst/rs_data are driven combinationally from the selected entry.
  - Once dispatch_valid=1 && dispatch_ready=0, the selection is locked; outputs stay stable until the handshake.
  - On handshake the entry becomes FREE and rs_valid is cleared.
  - Outputs are zero when dispatch_valid=0.
- Latency, for an instruction accepted in cycle C with no conflicts:
  - Requests in C+1, responses in C+2, dispatch_valid in C+3.
  - If all operands are x0: dispatch_valid in C+1.
  - Each extra same-bank operand adds 1 cycle.
- Simultaneous accept, request, response and dispatch on different entries in one cycle are all legal.

Test Plan:
- Warp 0, rs1=3, rs2=5, rs3=0, accepted cycle 0 -> bank 3 and bank 1 requested in cycle 1; dispatch_valid cycle 3 with rs_data = {bank3 data, bank1 data, 0}.
- Warp 0, rs1=1, rs2=5 (both bank 1) -> bank 1 requests reg 1 in cycle 1 and reg 5 in cycle 2; dispatch_valid in cycle 4.
- rs1=rs2=rs3=0 accepted cycle 0 -> no bank_req_valid; dispatch_valid cycle 1 with all-zero operands.
- dispatch_ready=0, issue 5 instructions back-to-back -> 4 accepted, inst_ready=0 from cycle 4; dispatch_inst held stable. Raise dispatch_ready -> round-robin dispatch order 0,1,2,3; 5th instruction accepted the cycle after the first free.
- Two collectors both needing bank 2 in the same cycle -> grants alternate per round-robin; no lost or duplicated operand.
- rst_n pulsed low while two entries are in COLLECT -> all outputs go to reset values immediately; a response the following cycle causes no dispatch.

Source files
------------

// File: rtl/gelato_operand_collector.sv
// Operand collector: holds issued instructions, reads rs1..rs3 from the banked warp register file,
// and dispatches each instruction with warp-wide operands. inst layout: {opaque, rs3, rs2, rs1, warp}.
module gelato_operand_collector #(
  parameter int NUM_COLLECTORS = 4,
  parameter int NUM_BANKS      = 4,
  parameter int NUM_RS         = 3,
  parameter int THREAD_NUM     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WARP_REG_WIDTH = THREAD_NUM * DATA_WIDTH,
  parameter int WARP_NUM_WIDTH = 3,
  parameter int REG_NUM_WIDTH  = 5,
  parameter int INST_WIDTH     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  inst_valid,
  output logic                                  inst_ready,
  input  logic [INST_WIDTH-1:0]                 inst,
  output logic [NUM_BANKS-1:0]                  bank_req_valid,
  output logic [NUM_BANKS*WARP_NUM_WIDTH-1:0]   bank_req_warp,
  output logic [NUM_BANKS*REG_NUM_WIDTH-1:0]    bank_req_reg,
  input  logic [NUM_BANKS-1:0]                  bank_rsp_valid,
  input  logic [NUM_BANKS*WARP_REG_WIDTH-1:0]   bank_rsp_data,
  output logic                                  dispatch_valid,
  input  logic                                  dispatch_ready,
  output logic [INST_WIDTH-1:0]                 dispatch_inst,
  output logic [NUM_RS*WARP_REG_WIDTH-1:0]      dispatch_rs_data
);

  localparam int CW  = (NUM_COLLECTORS > 1) ? $clog2(NUM_COLLECTORS) : 1;
  localparam int RW  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WW  = WARP_NUM_WIDTH;
  localparam int RGW = REG_NUM_WIDTH;
  localparam int DW  = WARP_REG_WIDTH;

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  logic [1:0]            state_q    [NUM_COLLECTORS];
  logic [1:0]            state_d    [NUM_COLLECTORS];
  logic [INST_WIDTH-1:0] inst_q     [NUM_COLLECTORS];
  logic [NUM_RS-1:0]     rs_valid_q [NUM_COLLECTORS];
  logic [NUM_RS-1:0]     rs_valid_d [NUM_COLLECTORS];
  logic [NUM_RS-1:0]     inflight_q [NUM_COLLECTORS];
  logic [NUM_RS-1:0]     inflight_d [NUM_COLLECTORS];
  logic [DW-1:0]         rs_data_q  [NUM_COLLECTORS][NUM_RS];

  logic [NUM_BANKS-1:0]  tag_valid_q;
  logic [CW-1:0]         tag_coll_q [NUM_BANKS];
  logic [RW-1:0]         tag_rs_q   [NUM_BANKS];
  logic [CW-1:0]         req_rr_q   [NUM_BANKS];
  logic [CW-1:0]         disp_rr_q;
  logic                  lock_q;
  logic [CW-1:0]         lock_idx_q;

  logic [RGW-1:0]        op_reg  [NUM_COLLECTORS][NUM_RS];
  logic [BW-1:0]         op_bank [NUM_COLLECTORS][NUM_RS];
  logic [NUM_RS-1:0]     pending [NUM_COLLECTORS];
  logic [NUM_COLLECTORS-1:0] free_vec;
  logic [NUM_BANKS-1:0]  grant_valid;
  logic [CW-1:0]         grant_coll [NUM_BANKS];
  logic [RW-1:0]         grant_rs   [NUM_BANKS];
  logic [NUM_BANKS-1:0]  rsp_hit;
  logic [NUM_RS-1:0]     cap_valid;
  logic [CW-1:0]         alloc_idx;
  logic                  accept;
  logic                  disp_found;
  logic [CW-1:0]         disp_sel;
  logic                  disp_fire;

  function automatic logic [CW-1:0] rr_inc(input logic [CW-1:0] x);
    return (int'(x) + 1 == NUM_COLLECTORS) ? '0 : x + 1'b1;
  endfunction

  for (genvar gc = 0; gc < NUM_COLLECTORS; gc++) begin : g_entry
    assign free_vec[gc] = (state_q[gc] == ST_FREE);
    for (genvar gr = 0; gr < NUM_RS; gr++) begin : g_rs
      assign op_reg[gc][gr]  = inst_q[gc][WW + gr*RGW +: RGW];
      assign op_bank[gc][gr] = op_reg[gc][gr][BW-1:0] + inst_q[gc][BW-1:0];
      assign pending[gc][gr] = (state_q[gc] == ST_COLLECT) && !rs_valid_q[gc][gr] && !inflight_q[gc][gr];
    end
  end

  for (genvar gr = 0; gr < NUM_RS; gr++) begin : g_cap
    assign cap_valid[gr] = (inst[WW + gr*RGW +: RGW] == '0);
  end

  assign inst_ready = |free_vec;
  assign accept     = inst_valid && inst_ready;

  always_comb begin
    alloc_idx = '0;
    for (int c = NUM_COLLECTORS - 1; c >= 0; c--) begin
      if (free_vec[c]) alloc_idx = CW'(c);
    end
  end

  // Per-bank round-robin over collectors; lowest pending rs index wins inside the chosen collector.
  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    logic          gnt_v;
    logic [CW-1:0] gnt_c;
    logic [RW-1:0] gnt_r;

    always_comb begin
      int idx;
      idx   = 0;
      gnt_v = 1'b0;
      gnt_c = '0;
      gnt_r = '0;
      for (int k = 0; k < NUM_COLLECTORS; k++) begin
        idx = (int'(req_rr_q[gb]) + k) % NUM_COLLECTORS;
        for (int r = 0; r < NUM_RS; r++) begin
          if (!gnt_v && pending[idx][r] && op_bank[idx][r] == BW'(gb)) begin
            gnt_v = 1'b1;
            gnt_c = CW'(idx);
            gnt_r = RW'(r);
          end
        end
      end
    end

    assign grant_valid[gb] = gnt_v;
    assign grant_coll[gb]  = gnt_c;
    assign grant_rs[gb]    = gnt_r;
    assign rsp_hit[gb]     = bank_rsp_valid[gb] && tag_valid_q[gb];
    assign bank_req_valid[gb]            = gnt_v;
    assign bank_req_warp[gb*WW +: WW]    = gnt_v ? inst_q[gnt_c][WW-1:0] : '0;
    assign bank_req_reg[gb*RGW +: RGW]   = gnt_v ? op_reg[gnt_c][gnt_r] : '0;
  end

  // A stalled offer stays pinned to the same entry until the handshake.
  always_comb begin
    int idx;
    idx        = 0;
    disp_found = 1'b0;
    disp_sel   = disp_rr_q;
    if (lock_q) begin
      disp_found = 1'b1;
      disp_sel   = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_COLLECTORS; k++) begin
        idx = (int'(disp_rr_q) + k) % NUM_COLLECTORS;
        if (!disp_found && state_q[idx] == ST_READY) begin
          disp_found = 1'b1;
          disp_sel   = CW'(idx);
        end
      end
    end
  end

  assign disp_fire      = disp_found && dispatch_ready;
  assign dispatch_valid = disp_found;
  assign dispatch_inst  = disp_found ? inst_q[disp_sel] : '0;

  for (genvar gr = 0; gr < NUM_RS; gr++) begin : g_disp
    assign dispatch_rs_data[gr*DW +: DW] = disp_found ? rs_data_q[disp_sel][gr] : '0;
  end

  always_comb begin
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      state_d[c]    = state_q[c];
      rs_valid_d[c] = rs_valid_q[c];
      inflight_d[c] = inflight_q[c];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant_valid[b]) inflight_d[grant_coll[b]][grant_rs[b]] = 1'b1;
      if (rsp_hit[b]) begin
        rs_valid_d[tag_coll_q[b]][tag_rs_q[b]] = 1'b1;
        inflight_d[tag_coll_q[b]][tag_rs_q[b]] = 1'b0;
      end
    end
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      if (state_q[c] == ST_COLLECT && (&rs_valid_d[c])) state_d[c] = ST_READY;
    end
    if (disp_fire) begin
      state_d[disp_sel]    = ST_FREE;
      rs_valid_d[disp_sel] = '0;
      inflight_d[disp_sel] = '0;
    end
    if (accept) begin
      state_d[alloc_idx]    = (&cap_valid) ? ST_READY : ST_COLLECT;
      rs_valid_d[alloc_idx] = cap_valid;
      inflight_d[alloc_idx] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_COLLECTORS; c++) begin
        state_q[c]    <= ST_FREE;
        inst_q[c]     <= '0;
        rs_valid_q[c] <= '0;
        inflight_q[c] <= '0;
      end
      tag_valid_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        tag_coll_q[b] <= '0;
        tag_rs_q[b]   <= '0;
        req_rr_q[b]   <= '0;
      end
      disp_rr_q  <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int c = 0; c < NUM_COLLECTORS; c++) begin
        state_q[c]    <= state_d[c];
        rs_valid_q[c] <= rs_valid_d[c];
        inflight_q[c] <= inflight_d[c];
      end
      if (accept) inst_q[alloc_idx] <= inst;
      // Responses arrive exactly one cycle after the grant, so a tag only lives one cycle.
      tag_valid_q <= grant_valid;
      for (int b = 0; b < NUM_BANKS; b++) begin
        tag_coll_q[b] <= grant_coll[b];
        tag_rs_q[b]   <= grant_rs[b];
        if (grant_valid[b]) req_rr_q[b] <= rr_inc(grant_coll[b]);
      end
      lock_q     <= disp_found && !dispatch_ready;
      lock_idx_q <= disp_sel;
      if (disp_fire) disp_rr_q <= rr_inc(disp_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_COLLECTORS; c++) begin
        for (int r = 0; r < NUM_RS; r++) rs_data_q[c][r] <= '0;
      end
    end else begin
      // Clearing at capture makes x0 operands read as zero without a separate path.
      if (accept) begin
        for (int r = 0; r < NUM_RS; r++) rs_data_q[alloc_idx][r] <= '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rsp_hit[b]) rs_data_q[tag_coll_q[b]][tag_rs_q[b]] <= bank_rsp_data[b*DW +: DW];
      end
    end
  end

endmodule
